// File: rtl/sdpram_fifo_ctrl_if.sv
// Bundle of the stream handshakes and the external SDPRAM port for
// sdpram_fifo_ctrl. The slave modport is the controller's view; the master
// modport is the view of the surrounding logic (stream source/sink plus RAM).
interface sdpram_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_afull;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH:0]   level;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  flush, s_valid, s_data, m_ready, ram_rd_data,
    output s_ready, s_afull, m_valid, m_data, level,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport master (
    output flush, s_valid, s_data, m_ready, ram_rd_data,
    input  s_ready, s_afull, m_valid, m_data, level,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// Single-clock FWFT FIFO controller driving an external distributed SDPRAM
// with a combinational read port. Words are committed to the RAM, then moved
// into a registered output stage that presents them on the m_* handshake.
module sdpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  sdpram_fifo_ctrl_if.slave  bus
);

  localparam int unsigned          DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  C_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_afull;
  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_m_data;

  logic                  w_m_valid;
  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_m_valid_nxt;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
  logic [ADDR_WIDTH:0]   w_level_nxt;

  // Handshake decode and next occupancy. A load needs a committed word, so
  // a word written this cycle is never the one being read.
  always_comb begin
    w_m_valid     = (r_state == ST_FULL);
    w_s_ready     = (r_ram_cnt != C_DEPTH);
    w_push        = bus.s_valid & w_s_ready;
    w_pop         = w_m_valid & bus.m_ready;
    w_load        = (r_ram_cnt != '0) & (~w_m_valid | w_pop);
    w_m_valid_nxt = w_load | (w_m_valid & ~w_pop);
    w_ram_cnt_nxt = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_push}
                              - {{ADDR_WIDTH{1'b0}}, w_load};
    w_level_nxt   = w_ram_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_m_valid_nxt};
  end

  // Pointers, RAM occupancy, output stage and registered level/afull.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_level   <= '0;
      r_afull   <= 1'b0;
      r_state   <= ST_EMPTY;
      r_m_data  <= '0;
    end else if (bus.flush) begin
      // m_data deliberately holds; only the bookkeeping is cleared.
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_level   <= '0;
      r_afull   <= 1'b0;
      r_state   <= ST_EMPTY;
    end else begin
      r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(w_push);
      r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(w_load);
      r_ram_cnt <= w_ram_cnt_nxt;
      r_level   <= w_level_nxt;
      r_afull   <= (w_level_nxt >= C_AFULL);
      r_state   <= w_m_valid_nxt ? ST_FULL : ST_EMPTY;
      if (w_load) begin
        r_m_data <= bus.ram_rd_data;
      end
    end
  end

  // Output drive; RAM writes are suppressed during flush and reset.
  always_comb begin
    bus.s_ready     = w_s_ready;
    bus.s_afull     = r_afull;
    bus.m_valid     = w_m_valid;
    bus.m_data      = r_m_data;
    bus.level       = r_level;
    bus.ram_wr_en   = w_push & ~bus.flush & rst_n;
    bus.ram_wr_addr = r_wr_ptr;
    bus.ram_wr_data = bus.s_data;
    bus.ram_rd_addr = r_rd_ptr;
  end

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Bench for sdpram_fifo_ctrl: behavioural SDPRAM plus a queue-based
// reference of the FIFO (RAM words as a queue, one output register).
module tb_sdpram_fifo_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned AFL   = 12;
  localparam int unsigned DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LEVEL(AFL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Distributed SDPRAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  assign bus.ram_rd_data = mem[bus.ram_rd_addr];

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            mv;
  logic [DW-1:0] md;
  int unsigned   pass_cnt  = 0;
  int unsigned   total_cnt = 0;

  function automatic int unsigned exp_level();
    return mq.size() + (mv ? 1 : 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    mv = 1'b0;
    md = '0;
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bit push, pop, ld;
    bus.s_valid = v; bus.s_data = d; bus.m_ready = r; bus.flush = f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      mv = 1'b0;
    end else begin
      push = v && (mq.size() != DEPTH);
      pop  = mv && r;
      ld   = (mq.size() > 0) && (!mv || pop);
      if (ld) begin
        md = mq.pop_front();
        mv = 1'b1;
      end else if (pop) begin
        mv = 1'b0;
      end
      if (push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'h77; bus.m_ready = 1'b0; bus.flush = 1'b0;
    #2;
    total_cnt++; if (bus.ram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", bus.ram_wr_en); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); else pass_cnt++;
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", bus.level); else pass_cnt++;
    total_cnt++; if (bus.s_afull !== 1'b0) $display("FAIL reset_afull: got %b expected 0", bus.s_afull); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data: got %h expected 00", bus.m_data); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_latency();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    step(1, 8'h11, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL lat_early_valid: got %b expected 0", bus.m_valid); else pass_cnt++;
    step(1, 8'h22, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL lat_first_valid: got %b expected 1", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== exp_d[0]) $display("FAIL lat_d0: got %h expected %h", bus.m_data, exp_d[0]); else pass_cnt++;
    step(1, 8'h33, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[1]) $display("FAIL lat_d1: got %b/%h expected 1/%h", bus.m_valid, bus.m_data, exp_d[1]); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[2]) $display("FAIL lat_d2: got %b/%h expected 1/%h", bus.m_valid, bus.m_data, exp_d[2]); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0 || bus.level !== 5'd0) $display("FAIL lat_drained: got %b/%0d expected 0/0", bus.m_valid, bus.level); else pass_cnt++;
  endtask

  task automatic test_fill_and_release();
    int unsigned accepted = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.s_ready) break;
      step(1, 8'(i + 1), 0, 0);
      accepted++;
      total_cnt++; if (bus.level !== 5'(exp_level())) $display("FAIL fill_level: got %0d expected %0d", bus.level, exp_level()); else pass_cnt++;
      total_cnt++; if (bus.s_afull !== (exp_level() >= AFL)) $display("FAIL fill_afull: got %b expected %b at level %0d", bus.s_afull, exp_level() >= AFL, exp_level()); else pass_cnt++;
    end
    total_cnt++; if (accepted != 17) $display("FAIL fill_accepted: got %0d expected 17", accepted); else pass_cnt++;
    total_cnt++; if (bus.level !== 5'd17) $display("FAIL fill_level17: got %0d expected 17", bus.level); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL fill_s_ready: got %b expected 0", bus.s_ready); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL rel_s_ready: got %b expected 1", bus.s_ready); else pass_cnt++;
    total_cnt++; if (bus.level !== 5'd16) $display("FAIL rel_level: got %0d expected 16", bus.level); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h02) $display("FAIL rel_m_data: got %h expected 02", bus.m_data); else pass_cnt++;
    step(1, 8'hC3, 0, 0);
    total_cnt++; if (bus.level !== 5'd17 || bus.s_ready !== 1'b0) $display("FAIL rel_refill: got level %0d ready %b expected 17/0", bus.level, bus.s_ready); else pass_cnt++;
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 42; i++) begin
      step(i < 40, 8'(i * 7 + 3), 1, 0);
      if (i >= 1 && i <= 40) begin
        total_cnt++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'((i - 1) * 7 + 3))
          $display("FAIL stream_word%0d: got %b/%h expected 1/%h", i - 1, bus.m_valid, bus.m_data, 8'((i - 1) * 7 + 3));
        else pass_cnt++;
      end
      total_cnt++; if (bus.level !== 5'(exp_level())) $display("FAIL stream_level: got %0d expected %0d", bus.level, exp_level()); else pass_cnt++;
    end
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL stream_end_valid: got %b expected 0", bus.m_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    total_cnt++; if (bus.level !== 5'd5) $display("FAIL flush_pre_level: got %0d expected 5", bus.level); else pass_cnt++;
    step(1, 8'hEE, 1, 1);
    total_cnt++; if (bus.level !== 5'd0 || bus.m_valid !== 1'b0) $display("FAIL flush_clear: got %0d/%b expected 0/0", bus.level, bus.m_valid); else pass_cnt++;
    step(1, 8'hA5, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL flush_early: got %b expected 0", bus.m_valid); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5) $display("FAIL flush_a5: got %b/%h expected 1/a5", bus.m_valid, bus.m_data); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL flush_no_ee: got %b/%h expected 0", bus.m_valid, bus.m_data); else pass_cnt++;
  endtask

  task automatic test_random();
    int unsigned pushed = 0, dut_out = 0, cyc = 0;
    logic v, r;
    logic [DW-1:0] d;
    while (pushed < 1000 && cyc < 10000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (v && mq.size() != DEPTH) pushed++;
      if (bus.m_valid && r) dut_out++;
      step(v, d, r, 0);
      cyc++;
      total_cnt++; if (bus.m_valid !== mv) $display("FAIL rnd_m_valid: got %b expected %b cycle %0d", bus.m_valid, mv, cyc); else pass_cnt++;
      total_cnt++; if (bus.m_data !== md) $display("FAIL rnd_m_data: got %h expected %h cycle %0d", bus.m_data, md, cyc); else pass_cnt++;
      total_cnt++; if (bus.level !== 5'(exp_level())) $display("FAIL rnd_level: got %0d expected %0d cycle %0d", bus.level, exp_level(), cyc); else pass_cnt++;
      total_cnt++; if (bus.s_ready !== (mq.size() != DEPTH)) $display("FAIL rnd_s_ready: got %b expected %b cycle %0d", bus.s_ready, mq.size() != DEPTH, cyc); else pass_cnt++;
      total_cnt++; if (bus.s_afull !== (exp_level() >= AFL)) $display("FAIL rnd_afull: got %b expected %b cycle %0d", bus.s_afull, exp_level() >= AFL, cyc); else pass_cnt++;
    end
    total_cnt++; if (pushed != 1000) $display("FAIL rnd_push_budget: got %0d expected 1000", pushed); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      if (bus.m_valid) dut_out++;
      step(0, 8'h00, 1, 0);
      total_cnt++; if (bus.m_valid !== mv || bus.m_data !== md) $display("FAIL rnd_drain: got %b/%h expected %b/%h", bus.m_valid, bus.m_data, mv, md); else pass_cnt++;
    end
    total_cnt++; if (dut_out != 1000) $display("FAIL rnd_out_count: got %0d expected 1000", dut_out); else pass_cnt++;
    total_cnt++; if (bus.level !== 5'd0) $display("FAIL rnd_final_level: got %0d expected 0", bus.level); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
    rst_n = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'hEE;
    #1;
    total_cnt++; if (bus.ram_wr_en !== 1'b0) $display("FAIL rmid_wr_en: got %b expected 0", bus.ram_wr_en); else pass_cnt++;
    total_cnt++; if (bus.level !== 5'd0 || bus.m_valid !== 1'b0) $display("FAIL rmid_clear: got %0d/%b expected 0/0", bus.level, bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b1 || bus.m_data !== 8'h00) $display("FAIL rmid_ready_data: got %b/%h expected 1/00", bus.s_ready, bus.m_data); else pass_cnt++;
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1, 8'h5A, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL rmid_early: got %b expected 0", bus.m_valid); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h5A) $display("FAIL rmid_5a: got %b/%h expected 1/5a", bus.m_valid, bus.m_data); else pass_cnt++;
    step(0, 8'h00, 1, 0);
    total_cnt++; if (bus.m_valid !== 1'b0 || bus.level !== 5'd0) $display("FAIL rmid_empty: got %b/%0d expected 0/0", bus.m_valid, bus.level); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_and_release();
    test_stream();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
